// File: rtl/memory_responder.sv
// memory_responder: MAR/MBR word memory responder, one outstanding request, DEPTH x 16 array.
// Latency: response valid WAIT_STATES+1 cycles after request accept; req_ready only in IDLE.
// Backpressure: response held stable in RESP until rsp_ready. Option: MEMORY_RESPONDER_ADDR_CHECK_EN.
`timescale 1ns/1ps
module memory_responder #(
  parameter int DEPTH       = 16384,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          lat_write;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          access;

  assign idx       = lat_addr[AW-1:0];
  assign access    = (state == ST_WAIT) && (cnt == 4'd0);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  logic err_q;

  assign in_range = ({1'b0, lat_addr} < 17'(DEPTH));
  assign rsp_err  = err_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (access)
      err_q <= !in_range;
  end
`else
  assign in_range = 1'b1;
  assign rsp_err  = 1'b0;

  // Upper address bits are dropped: the index wraps modulo DEPTH.
  if (AW < 16) begin : g_wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^lat_addr[15:AW];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      lat_write <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= 4'(WAIT_STATES);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!in_range)
              rsp_rdata <= 16'h0000;
            else if (lat_write)
              rsp_rdata <= lat_wdata;
            else
              rsp_rdata <= mem[idx];
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is never reset; a reset coinciding with the access edge blocks the commit.
  always_ff @(posedge clk) begin
    if (!reset && access && lat_write && in_range)
      mem[idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: WAIT_STATES=2 instance for protocol/data, WAIT_STATES=0 for throughput.
`timescale 1ns/1ps
module tb_memory_responder;
  logic        clk;
  logic        reset, req_valid, req_write, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        reset0, req_valid0, req_write0, rsp_ready0;
  logic [15:0] req_addr0, req_wdata0;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [15:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];
  logic [15:0] exp_q0 [$];

  memory_responder #(.DEPTH(16384), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  memory_responder #(.DEPTH(16384), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // abort: 0 normal, 1 reset one cycle after accept, 2 reset while in RESP
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_d, input logic exp_e, input int bp,
                        input logic present_next, input int abort, input string tag);
    int n;
    int seen;
    logic [16:0] e;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, " req_ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (abort == 1) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
        if (rsp_valid || busy) seen++;
        @(posedge clk); #1;
      end
      check({tag, " no_rsp"}, seen, 0);
      return;
    end
    exp_q.push_back({exp_e, exp_d});
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, 3);
    e = exp_q.pop_front();
    check({tag, " rdata"}, rsp_rdata, e[15:0]);
    check({tag, " err"}, rsp_err, e[16]);
    if (abort == 2) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check({tag, " rst_valid"}, rsp_valid, 0);
      check({tag, " rst_busy"}, busy, 0);
      return;
    end
    if (present_next) begin
      req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'h5555; req_valid = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({tag, " bp_valid"}, rsp_valid, 1);
      check({tag, " bp_rdata"}, rsp_rdata, e[15:0]);
      check({tag, " bp_ready"}, req_ready, 0);
      check({tag, " bp_busy"}, busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " post_valid"}, rsp_valid, 0);
    check({tag, " post_ready"}, req_ready, 1);
  endtask

  initial begin
    int last_acc;
    int n_acc;
    int n_rsp;
    logic acc_pending;
    clk = 1'b0;
    reset = 1'b1; reset0 = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 16'h0; req_wdata0 = 16'h0; rsp_ready0 = 1'b0;

    // Reset held for 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom); req_write = 1'($urandom); rsp_ready = 1'($urandom);
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
      @(posedge clk); #1;
      check("rst rsp_valid", rsp_valid, 0);
      check("rst rsp_rdata", rsp_rdata, 0);
      check("rst rsp_err", rsp_err, 0);
      check("rst busy", busy, 0);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    reset = 1'b0; reset0 = 1'b0;
    check("release req_ready", req_ready, 1);
    @(posedge clk); #1;
    check("idle req_ready", req_ready, 1);
    check("idle busy", busy, 0);

    do_req(1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0, 0, 1'b0, 0, "wr10");
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0, 1'b0, 0, "rd10");
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 5, 1'b1, 0, "rd10_bp");
    do_req(1'b1, 16'h0030, 16'h5555, 16'h5555, 1'b0, 0, 1'b0, 0, "wr30");
    do_req(1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0, 0, 1'b0, 0, "rd30");

    do_req(1'b1, 16'h0005, 16'h0777, 16'h0777, 1'b0, 0, 1'b0, 0, "wr05");
`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
    do_req(1'b1, 16'h4005, 16'h1111, 16'h0000, 1'b1, 0, 1'b0, 0, "wr4005");
    do_req(1'b0, 16'h0005, 16'h0000, 16'h0777, 1'b0, 0, 1'b0, 0, "rd05");
    do_req(1'b0, 16'h4005, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 0, "rd4005");
`else
    do_req(1'b1, 16'h4005, 16'h1111, 16'h1111, 1'b0, 0, 1'b0, 0, "wr4005");
    do_req(1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0, 0, 1'b0, 0, "rd05");
`endif
    do_req(1'b1, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0, 0, 1'b0, 0, "wr0000");
    do_req(1'b1, 16'h3FFF, 16'h5A5A, 16'h5A5A, 1'b0, 0, 1'b0, 0, "wr3fff");
    do_req(1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 0, 1'b0, 0, "rd0000");
    do_req(1'b0, 16'h3FFF, 16'h0000, 16'h5A5A, 1'b0, 0, 1'b0, 0, "rd3fff");

    do_req(1'b1, 16'h0020, 16'hAAAA, 16'hAAAA, 1'b0, 0, 1'b0, 0, "wr20_old");
    do_req(1'b1, 16'h0020, 16'h1234, 16'h1234, 1'b0, 0, 1'b0, 1, "wr20_wait_rst");
    do_req(1'b0, 16'h0020, 16'h0000, 16'hAAAA, 1'b0, 0, 1'b0, 0, "rd20_a");
    do_req(1'b1, 16'h0020, 16'h1234, 16'h1234, 1'b0, 0, 1'b0, 2, "wr20_resp_rst");
    do_req(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 0, 1'b0, 0, "rd20_b");

    // WAIT_STATES=0: back-to-back writes with rsp_ready held high
    req_write0 = 1'b1; req_addr0 = 16'h0100; req_wdata0 = 16'hC000;
    req_valid0 = 1'b1; rsp_ready0 = 1'b1;
    last_acc = -1; n_acc = 0; n_rsp = 0; acc_pending = 1'b0;
    for (int c = 0; c < 21; c++) begin
      if (acc_pending) begin
        req_wdata0 = req_wdata0 + 16'h0001;
        req_addr0  = req_addr0 + 16'h0001;
        acc_pending = 1'b0;
      end
      if (rsp_valid0) begin
        n_rsp++;
        check("ws0 latency", c - last_acc, 2);
        if (exp_q0.size() > 0) check("ws0 rdata", rsp_rdata0, exp_q0.pop_front());
        check("ws0 err", rsp_err0, 0);
      end
      if (req_valid0 && req_ready0) begin
        if (last_acc >= 0) check("ws0 period", c - last_acc, 3);
        exp_q0.push_back(req_wdata0);
        last_acc = c;
        n_acc++;
        acc_pending = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid0 = 1'b0;
    check("ws0 accepts", n_acc >= 6, 1);
    check("ws0 responses", n_rsp >= 6, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
